// File: rtl/ttl_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// ttl_decoder_arbiter
//
// Round-robin arbiter that shares one 2-to-4 (generally WIDTH_IN-to-WIDTH_OUT)
// inverted-output decoder between WIDTH_OUT requesters. It drives the decoder
// select (A) and active-low enable directly, and also produces the equivalent
// registered inverted one-hot grant vector. One guard cycle with everything
// deasserted separates consecutive grants (break-before-make).
//
// Optional build macro:
//   DECODER_ARB_FIXED_PRIORITY_EN - search always starts at index 0, so the
//   lowest requesting index wins and no rotation state is kept.
//
// Ports:
//   Clk         in   1          rising-edge clock
//   Clear_bar   in   1          asynchronous active-low reset
//   Request     in   WIDTH_OUT  active-high request per requester
//   A           out  WIDTH_IN   decoder select (current / last grantee)
//   Enable_bar  out  1          active-low decoder enable, low only in GRANT
//   Grant_bar   out  WIDTH_OUT  inverted one-hot grant, bit A low only in GRANT
//   Busy        out  1          high in GRANT and GUARD
// ---------------------------------------------------------------------------
module ttl_decoder_arbiter #(
    parameter int WIDTH_OUT  = 4,
    parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
    parameter int MAX_HOLD   = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic [WIDTH_OUT-1:0] Request,
    output logic [WIDTH_IN-1:0]  A,
    output logic                 Enable_bar,
    output logic [WIDTH_OUT-1:0] Grant_bar,
    output logic                 Busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                 state_r;
    logic [WIDTH_IN-1:0]    a_r;
    logic                   enable_bar_r;
    logic [WIDTH_OUT-1:0]   grant_bar_r;
    logic                   busy_r;
    logic [CW-1:0]          count_r;

    logic [WIDTH_IN-1:0]    start_s;
    logic [WIDTH_IN-1:0]    idx_s;
    logic [WIDTH_IN-1:0]    winner_s;
    logic                   found_s;

    // Decoder output pattern with enable asserted: only output 'sel' is low.
    function automatic logic [WIDTH_OUT-1:0] decode_bar(input logic [WIDTH_IN-1:0] sel);
        decode_bar = ~({{(WIDTH_OUT-1){1'b0}}, 1'b1} << sel);
    endfunction

`ifdef DECODER_ARB_FIXED_PRIORITY_EN
    assign start_s = {WIDTH_IN{1'b0}};
`else
    logic [WIDTH_IN-1:0] pointer_r;
    assign start_s = pointer_r;
`endif

    // Cyclic search from start_s; iterating downwards lets the nearest set bit
    // overwrite farther ones. Index arithmetic wraps because WIDTH_OUT is 2^n.
    always_comb begin
        idx_s    = {WIDTH_IN{1'b0}};
        winner_s = {WIDTH_IN{1'b0}};
        for (int i = WIDTH_OUT - 1; i >= 0; i--) begin
            idx_s    = start_s + WIDTH_IN'(i);
            winner_s = Request[idx_s] ? idx_s : winner_s;
        end
        found_s = |Request;
    end

    // Arbitration state machine with registered decoder-facing outputs.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state_r      <= ST_IDLE;
            a_r          <= {WIDTH_IN{1'b0}};
            enable_bar_r <= 1'b1;
            grant_bar_r  <= {WIDTH_OUT{1'b1}};
            busy_r       <= 1'b0;
            count_r      <= {CW{1'b0}};
`ifndef DECODER_ARB_FIXED_PRIORITY_EN
            pointer_r    <= {WIDTH_IN{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_GRANT: begin
                    if (!Request[a_r] || (count_r == MAX_HOLD_C)) begin
                        // Drop enable first; A is held so the select is stable
                        // across the enable edge.
                        state_r      <= ST_GUARD;
                        enable_bar_r <= 1'b1;
                        grant_bar_r  <= {WIDTH_OUT{1'b1}};
                        busy_r       <= 1'b1;
                        count_r      <= {CW{1'b0}};
`ifndef DECODER_ARB_FIXED_PRIORITY_EN
                        pointer_r    <= a_r + WIDTH_IN'(1);
`endif
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ST_IDLE, ST_GUARD: begin
                    if (found_s) begin
                        state_r      <= ST_GRANT;
                        a_r          <= winner_s;
                        enable_bar_r <= 1'b0;
                        grant_bar_r  <= decode_bar(winner_s);
                        busy_r       <= 1'b1;
                        count_r      <= CW'(1);
                    end else begin
                        state_r      <= ST_IDLE;
                        enable_bar_r <= 1'b1;
                        grant_bar_r  <= {WIDTH_OUT{1'b1}};
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    enable_bar_r <= 1'b1;
                    grant_bar_r  <= {WIDTH_OUT{1'b1}};
                    busy_r       <= 1'b0;
                    count_r      <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) A          = a_r;
    assign #(DELAY_RISE, DELAY_FALL) Enable_bar = enable_bar_r;
    assign #(DELAY_RISE, DELAY_FALL) Grant_bar  = grant_bar_r;
    assign #(DELAY_RISE, DELAY_FALL) Busy       = busy_r;

endmodule

// File: tb/tb_ttl_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ttl_decoder_arbiter
//
// Scoreboard bench: each driven cycle advances a small reference model of the
// arbiter, pushes the expected outputs to a queue, and after the clock edge
// the scenario task pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_ttl_decoder_arbiter;

    localparam int MH = 8;

    logic       Clk = 1'b0;
    logic       Clear_bar = 1'b0;
    logic [3:0] Request = 4'b0000;
    logic [1:0] A;
    logic       Enable_bar;
    logic [3:0] Grant_bar;
    logic       Busy;

    ttl_decoder_arbiter #(
        .WIDTH_OUT (4),
        .WIDTH_IN  (2),
        .MAX_HOLD  (MH),
        .DELAY_RISE(0),
        .DELAY_FALL(0)
    ) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Request   (Request),
        .A         (A),
        .Enable_bar(Enable_bar),
        .Grant_bar (Grant_bar),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0] a;
        logic       en_bar;
        logic [3:0] gnt_bar;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: 0 = IDLE, 1 = GRANT, 2 = GUARD.
    int         m_state;
    logic [1:0] m_a;
    logic [1:0] m_ptr;
    int         m_cnt;

    task automatic model_reset();
        m_state = 0;
        m_a     = 2'd0;
        m_ptr   = 2'd0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [3:0] req);
        logic [1:0] start;
        logic [1:0] idx;
        logic       hit;
        if (m_state == 1) begin
            if (!req[m_a] || m_cnt == MH) begin
                m_state = 2;
                m_ptr   = m_a + 2'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
`ifdef DECODER_ARB_FIXED_PRIORITY_EN
            start = 2'd0;
`else
            start = m_ptr;
`endif
            hit = 1'b0;
            for (int i = 0; i < 4; i++) begin
                idx = start + 2'(i);
                if (!hit && req[idx]) begin
                    hit = 1'b1;
                    m_a = idx;
                end
            end
            if (hit) begin
                m_state = 1;
                m_cnt   = 1;
            end else begin
                m_state = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.a       = m_a;
        e.en_bar  = (m_state != 1);
        e.gnt_bar = (m_state == 1) ? ~(4'b0001 << m_a) : 4'b1111;
        e.busy    = (m_state != 0);
        return e;
    endfunction

    // Drive one cycle of Request, push the model's expectation, wait the edge.
    task automatic drive(input logic [3:0] req);
        Request = req;
        model_step(req);
        sb_q.push_back(model_out());
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Clear_bar = 1'b0;
        Request   = 4'b0000;
        @(posedge Clk);
        #1;
        Clear_bar = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    task automatic test_reset();
        Clear_bar = 1'b0;
        Request   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== {2'd0, 1'b1, 4'b1111, 1'b0}) begin
                n_fail++;
                $display("FAIL reset: got %b required %b", {A, Enable_bar, Grant_bar, Busy},
                         {2'd0, 1'b1, 4'b1111, 1'b0});
            end
        end
        Clear_bar = 1'b1;
        Request   = 4'b0000;
        model_reset();
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(4'b0100);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e) begin
                n_fail++;
                $display("FAIL single[%0d]: got %b required %b", i, {A, Enable_bar, Grant_bar, Busy}, e);
            end
            if (i == 0 || i == 9) begin
                n_checks++;
                if (A !== 2'd2 || Grant_bar !== 4'b1011 || Enable_bar !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_grant[%0d]: A=%0d grant_bar=%b required A=2 grant_bar=1011", i, A, Grant_bar);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (Grant_bar !== 4'b1111 || Busy !== 1'b1 || Enable_bar !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_guard: grant_bar=%b busy=%b required 1111/1", Grant_bar, Busy);
                end
            end
        end
    endtask

    task automatic test_rotation();
        exp_t       e;
        logic [1:0] order[$];
        logic       prev_en_bar;
        logic [1:0] want;
        prev_en_bar = 1'b1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(4'b1111);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got %b required %b", i, {A, Enable_bar, Grant_bar, Busy}, e);
            end
            n_checks++;
            if (($countones(~Grant_bar) > 1) || ((Enable_bar == 1'b0) != (Grant_bar != 4'b1111))) begin
                n_fail++;
                $display("FAIL rotation_invariant[%0d]: en_bar=%b grant_bar=%b", i, Enable_bar, Grant_bar);
            end
            if (prev_en_bar === 1'b1 && Enable_bar === 1'b0) order.push_back(A);
            prev_en_bar = Enable_bar;
        end
        n_checks++;
        if (order.size() < 5) begin
            n_fail++;
            $display("FAIL rotation_count: tenures=%0d required 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
`ifdef DECODER_ARB_FIXED_PRIORITY_EN
                want = 2'd0;
`else
                want = 2'(k);
`endif
                n_checks++;
                if (order[k] !== want) begin
                    n_fail++;
                    $display("FAIL rotation_order[%0d]: got %0d required %0d", k, order[k], want);
                end
            end
        end
    endtask

    task automatic test_early_release();
        exp_t       e;
        logic [3:0] seq[5];
        logic [1:0] want;
        seq = '{4'b1010, 4'b1011, 4'b1011, 4'b1001, 4'b1001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e) begin
                n_fail++;
                $display("FAIL early[%0d]: got %b required %b", i, {A, Enable_bar, Grant_bar, Busy}, e);
            end
        end
`ifdef DECODER_ARB_FIXED_PRIORITY_EN
        want = 2'd0;
`else
        want = 2'd3;
`endif
        n_checks++;
        if (A !== want || Enable_bar !== 1'b0) begin
            n_fail++;
            $display("FAIL early_next: A=%0d en_bar=%b required A=%0d en_bar=0", A, Enable_bar, want);
        end
    endtask

    task automatic test_async_clear();
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e) begin
                n_fail++;
                $display("FAIL clear_pre[%0d]: got %b required %b", i, {A, Enable_bar, Grant_bar, Busy}, e);
            end
        end
        #3;
        Clear_bar = 1'b0;
        #1;
        n_checks++;
        if ({A, Enable_bar, Grant_bar, Busy} !== {2'd0, 1'b1, 4'b1111, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_now: got %b required %b", {A, Enable_bar, Grant_bar, Busy},
                     {2'd0, 1'b1, 4'b1111, 1'b0});
        end
        #1;
        Clear_bar = 1'b1;
        model_reset();
        drive(4'b1111);
        e = sb_q.pop_front();
        n_checks++;
        if ({A, Enable_bar, Grant_bar, Busy} !== e || A !== 2'd0 || Grant_bar !== 4'b1110) begin
            n_fail++;
            $display("FAIL clear_after: got %b required %b", {A, Enable_bar, Grant_bar, Busy}, e);
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic [3:0] req;
        do_reset();
        req = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            drive(req);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%b got %b required %b", i, req,
                         {A, Enable_bar, Grant_bar, Busy}, e);
            end
        end
    endtask

`ifdef DECODER_ARB_FIXED_PRIORITY_EN
    task automatic test_fixed_priority();
        exp_t e;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            drive(4'b1010);
            e = sb_q.pop_front();
            n_checks++;
            if ({A, Enable_bar, Grant_bar, Busy} !== e || (Enable_bar === 1'b0 && A !== 2'd1)) begin
                n_fail++;
                $display("FAIL fixed[%0d]: got %b required %b", i, {A, Enable_bar, Grant_bar, Busy}, e);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_async_clear();
        test_random();
`ifdef DECODER_ARB_FIXED_PRIORITY_EN
        test_fixed_priority();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
